// File: rtl/mod_addsub_pipe.sv
// Multi-lane two-stage pipelined modular add/subtract: r = (a +/- b +/- c) mod P per lane,
// with valid/ready handshake, per-lane operand range flags and a saturating error counter.
module mod_addsub_pipe #(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      LANES = 4,
  parameter logic [WIDTH-1:0] P     = 32'hC0000001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] in_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_r,
  output logic [LANES-1:0]       out_err,
  output logic [7:0]             err_count
);

  typedef enum logic [1:0] {
    OpAddSub = 2'd0,
    OpAdd    = 2'd1,
    OpSub    = 2'd2,
    OpSubSub = 2'd3
  } op_e;

  localparam int unsigned   EW    = WIDTH + 1;
  localparam logic [WIDTH:0] P_EXT = {1'b0, P};

  // Pipeline state
  logic                   s1_valid_q;
  op_e                    s1_op_q;
  logic [LANES*EW-1:0]    s1_s_q;
  logic [LANES*WIDTH-1:0] s1_c_q;
  logic [LANES-1:0]       s1_err_q;

  logic                   s2_valid_q;
  logic [LANES*WIDTH-1:0] s2_r_q;
  logic [LANES-1:0]       s2_err_q;
  logic [7:0]             err_count_q;

  // Next-state of the datapath
  op_e                    in_op_e;
  logic [LANES*EW-1:0]    s1_s_d;
  logic [LANES-1:0]       s1_err_d;
  logic [LANES*WIDTH-1:0] s2_r_d;

  // Handshake
  logic s2_load;
  logic s1_load;
  logic out_fire;

  assign in_op_e  = op_e'(in_op);
  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // Stage 1: a +/- b with a single conditional correction, plus operand range check
  for (genvar i = 0; i < LANES; i++) begin : g_s1
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sum_red;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   s;
    logic             use_b;
    logic             use_c;

    assign a       = in_a[i*WIDTH +: WIDTH];
    assign b       = in_b[i*WIDTH +: WIDTH];
    assign c       = in_c[i*WIDTH +: WIDTH];
    assign sum     = {1'b0, a} + {1'b0, b};
    assign sum_red = (sum >= P_EXT) ? (sum - P_EXT) : sum;
    assign diff    = {1'b0, a} - {1'b0, b} + ((a < b) ? P_EXT : '0);

    assign use_b = (in_op_e != OpSub);
    assign use_c = (in_op_e != OpAdd);

    always_comb begin
      s = {1'b0, a};
      unique case (in_op_e)
        OpAddSub, OpAdd: s = sum_red;
        OpSub:           s = {1'b0, a};
        OpSubSub:        s = diff;
        default:         s = {1'b0, a};
      endcase
    end

    assign s1_s_d[i*EW +: EW] = s;
    assign s1_err_d[i]        = (a >= P) || (use_b && (b >= P)) || (use_c && (c >= P));
  end

  // Stage 2: subtract c with wrap-around correction; add-only passes the partial through
  for (genvar i = 0; i < LANES; i++) begin : g_s2
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] c;
    logic             neg;
    logic [WIDTH-1:0] r_sub;

    assign s     = s1_s_q[i*EW +: EW];
    assign c     = s1_c_q[i*WIDTH +: WIDTH];
    assign neg   = (s < {1'b0, c});
    // Modulo-2^WIDTH arithmetic equals truncating the (WIDTH+1)-bit result
    assign r_sub = s[WIDTH-1:0] - c + (neg ? P : '0);

    assign s2_r_d[i*WIDTH +: WIDTH] = (s1_op_q == OpAdd) ? s[WIDTH-1:0] : r_sub;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OpAddSub;
      s1_s_q     <= '0;
      s1_c_q     <= '0;
      s1_err_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (s1_load) begin
        s1_op_q  <= in_op_e;
        s1_s_q   <= s1_s_d;
        s1_c_q   <= in_c;
        s1_err_q <= s1_err_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_r_q     <= '0;
      s2_err_q   <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_r_q   <= s2_r_d;
        s2_err_q <= s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= '0;
    end else if (out_fire && (|s2_err_q) && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_r     = s2_r_q;
  assign out_err   = s2_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed self-checking bench for mod_addsub_pipe (WIDTH=32, LANES=4, P=0xC0000001).
module tb_mod_addsub_pipe;

  localparam logic [31:0] P = 32'hC0000001;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_op = 2'd0;
  logic [127:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic [127:0] in_c = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_r;
  logic [3:0]   out_err;
  logic [7:0]   err_count;

  int total = 0;
  int bad   = 0;

  mod_addsub_pipe #(.WIDTH(32), .LANES(4), .P(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_lane(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c);
    longint v;
    v = longint'(a);
    if (op == 2'd0 || op == 2'd1) v = v + longint'(b);
    if (op == 2'd3) v = v - longint'(b);
    if (op != 2'd1) v = v - longint'(c);
    v = v % longint'(P);
    if (v < 0) v = v + longint'(P);
    return v[31:0];
  endfunction

  function automatic logic [127:0] ref_vec(input logic [1:0] op, input logic [127:0] a,
                                           input logic [127:0] b, input logic [127:0] c);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = ref_lane(op, a[l*32 +: 32], b[l*32 +: 32],
                                                          c[l*32 +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [127:0] a,
                        input logic [127:0] b, input logic [127:0] c);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_c     = c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++;
    if (out_r !== '0) begin bad++; $display("FAIL rst_out_r got=%h exp=0", out_r); end
    total++;
    if (out_err !== 4'b0) begin bad++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
    reset = 1'b0;
    tick();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_op0_latency();
    logic [127:0] exp;
    exp = pack4(32'd3221225465, 32'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    set_in(1'b1, 2'd0, pack4(5, 0, 0, 0), pack4(7, 0, 0, 0), pack4(20, 0, 0, 0));
    tick();
    set_in(1'b0, 2'd0, '0, '0, '0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL lat1_out_valid got=%b exp=0", out_valid); end
    tick();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL lat2_out_valid got=%b exp=1", out_valid); end
    total++;
    if (out_r !== exp) begin bad++; $display("FAIL op0_result got=%h exp=%h", out_r, exp); end
    total++;
    if (out_err !== 4'b0) begin bad++; $display("FAIL op0_err got=%b exp=0", out_err); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL op0_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_ops();
    logic [127:0] pm1;
    logic [127:0] exp;
    pm1 = pack4(P - 1, P - 1, P - 1, P - 1);
    exp = pack4(P - 2, P - 2, P - 2, P - 2);
    set_in(1'b1, 2'd1, pm1, pm1, pack4(5, 5, 5, 5));
    tick();
    set_in(1'b1, 2'd3, '0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    tick();
    set_in(1'b0, 2'd0, '0, '0, '0);
    total++;
    if (out_r !== exp || out_valid !== 1'b1) begin
      bad++; $display("FAIL op1_result got=%h v=%b exp=%h", out_r, out_valid, exp);
    end
    tick();
    total++;
    if (out_r !== exp || out_valid !== 1'b1) begin
      bad++; $display("FAIL op3_result got=%h v=%b exp=%h", out_r, out_valid, exp);
    end
    total++;
    if (out_err !== 4'b0) begin bad++; $display("FAIL op3_err got=%b exp=0", out_err); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] a [3];
    logic [127:0] b [3];
    logic [127:0] c [3];
    logic [127:0] e [3];
    for (int k = 0; k < 3; k++) begin
      a[k] = pack4(100 * k + 50, 100 * k + 51, P - 1 - k, 100 * k + 53);
      b[k] = pack4(k, 7 + k, 14 + k, P - 1);
      c[k] = pack4(1, 4, 7, 10 + k);
      e[k] = ref_vec(2'(k), a[k], b[k], c[k]);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 2'(k), a[k], b[k], c[k]);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept%0d got=%b exp=1", k, in_ready); end
      tick();
    end
    set_in(1'b1, 2'd2, a[2], b[2], c[2]);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    tick();
    tick();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b exp=0", in_ready); end
    total++;
    if (out_valid !== 1'b1 || out_r !== e[0]) begin
      bad++; $display("FAIL bp_stable got=%h v=%b exp=%h", out_r, out_valid, e[0]);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    set_in(1'b0, 2'd0, '0, '0, '0);
    for (int k = 1; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_r !== e[k]) begin
        bad++; $display("FAIL bp_order%0d got=%h v=%b exp=%h", k, out_r, out_valid, e[k]);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic [127:0] ta [N];
    logic [127:0] tb [N];
    logic [127:0] tc [N];
    logic [1:0]   top [N];
    logic [127:0] q [$];
    logic [31:0]  pat;
    int idx;
    int recv;
    pat = 32'b1011_0011_1110_0101_1101_1000_1111_0110;
    for (int k = 0; k < N; k++) begin
      top[k] = 2'(k % 4);
      for (int l = 0; l < 4; l++) begin
        ta[k][l*32 +: 32] = $urandom_range(32'hC0000000);
        tb[k][l*32 +: 32] = $urandom_range(32'hC0000000);
        tc[k][l*32 +: 32] = $urandom_range(32'hC0000000);
      end
    end
    ta[0] = pack4(P - 1, 0, P - 1, 0);
    tb[0] = pack4(P - 1, 0, 0, P - 1);
    tc[0] = pack4(0, P - 1, P - 1, P - 1);
    idx = 0;
    recv = 0;
    for (int cyc = 0; cyc < 300 && recv < N; cyc++) begin
      if (idx < N) set_in(1'b1, top[idx], ta[idx], tb[idx], tc[idx]);
      else set_in(1'b0, 2'd0, '0, '0, '0);
      out_ready = pat[cyc % 32];
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got=%h exp=none", out_r);
        end else if (out_r !== q[0] || out_err !== 4'b0) begin
          bad++; $display("FAIL b2b_item%0d got=%h err=%b exp=%h", recv, out_r, out_err, q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_vec(top[idx], ta[idx], tb[idx], tc[idx]));
        idx++;
      end
      tick();
    end
    set_in(1'b0, 2'd0, '0, '0, '0);
    out_ready = 1'b1;
    total++;
    if (recv != N) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", recv, N); end
  endtask

  task automatic test_err_sat();
    logic [127:0] exp;
    int sent;
    int recv;
    int exp_cnt;
    exp = pack4(7, 7, P - 3, 7);
    sent = 0;
    recv = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && recv < 300; cyc++) begin
      // b is out of range on every lane but unused by op 2, so only lane 2 flags
      set_in(sent < 300, 2'd2, pack4(10, 10, P, 10), pack4(P, P, P, P), pack4(3, 3, 3, 3));
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        recv++;
        total++;
        if (out_err !== 4'b0100) begin bad++; $display("FAIL sat_err got=%b exp=0100", out_err); end
        total++;
        if (out_r !== exp) begin bad++; $display("FAIL sat_result got=%h exp=%h", out_r, exp); end
      end
      tick();
      exp_cnt = (recv > 255) ? 255 : recv;
      total++;
      if (err_count !== 8'(exp_cnt)) begin
        bad++; $display("FAIL sat_count got=%0d exp=%0d", err_count, exp_cnt);
      end
    end
    set_in(1'b0, 2'd0, '0, '0, '0);
    total++;
    if (recv != 300 || err_count !== 8'd255) begin
      bad++; $display("FAIL sat_final got=%0d/%0d exp=300/255", recv, err_count);
    end
  endtask

  task automatic test_reset_midflight();
    logic [127:0] exp;
    exp = pack4(32'd3221225465, 32'd0, 32'd0, 32'd0);
    out_ready = 1'b0;
    set_in(1'b1, 2'd1, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), '0);
    tick();
    tick();
    set_in(1'b0, 2'd0, '0, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", out_valid); end
    total++;
    if (err_count !== 8'd0) begin bad++; $display("FAIL mrst_count got=%0d exp=0", err_count); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%b exp=1", in_ready); end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_stale%0d got=%b exp=0", k, out_valid); end
    end
    set_in(1'b1, 2'd0, pack4(5, 0, 0, 0), pack4(7, 0, 0, 0), pack4(20, 0, 0, 0));
    tick();
    set_in(1'b0, 2'd0, '0, '0, '0);
    tick();
    total++;
    if (out_valid !== 1'b1 || out_r !== exp) begin
      bad++; $display("FAIL mrst_new got=%h v=%b exp=%h", out_r, out_valid, exp);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_op0_latency();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_err_sat();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
Multi-lane, two-stage pipelined modular add/subtract unit. Computes r = (a ± b ± c) mod P per lane, with all inputs and results in [0, P). It is the parametrised successor of the single-lane f+z−d reduction step used after the multiplier in the NTT/modular datapath. It adds a per-transaction opcode, a valid/ready handshake with backpressure, and range-error detection.

Parameters:
WIDTH, 32, bit width of each operand and result lane
LANES, 4, number of independent lanes processed per transaction
P, 32'hC0000001 (3221225473), modulus; legal range 2 <= P <= 2^WIDTH−1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  unit can accept a transaction this cycle
in_op  in  2  operation: 0 = a+b−c, 1 = a+b, 2 = a−c, 3 = a−b−c
in_a  in  LANES*WIDTH  operand a; lane i occupies bits [i*WIDTH +: WIDTH]
in_b  in  LANES*WIDTH  operand b
in_c  in  LANES*WIDTH  operand c
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_r  out  LANES*WIDTH  results, same lane packing as the inputs
out_err  out  LANES  per-lane flag: at least one operand of that lane was >= P
err_count  out  8  saturating count of transactions with any out_err bit set

Behaviour:
- Reset (async assert, sync-style release): both stage valid bits = 0, out_valid = 0, out_r = 0, out_err = 0, err_count = 0. in_ready is 1 during and after reset.
- Handshake: input is accepted on a cycle when in_valid && in_ready; output is consumed on a cycle when out_valid && out_ready. Once out_valid is high, out_r, out_err and out_valid stay stable until consumed.
- Pipeline: stage 1 registers the partial result; stage 2 registers the final result and drives the outputs.
  - Stage 2 loads when it is empty or its content is being consumed this cycle.
  - Stage 1 loads when it is empty or is moving into stage 2 this cycle.
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready, with no combinational path from in_valid.
- Latency: 2 cycles from acceptance to out_valid when unstalled. Throughput: 1 transaction per cycle. Maximum occupancy: 2 transactions.
- Stage 1 arithmetic, per lane, (WIDTH+1)-bit intermediates:
  - op 0/1: s = a+b; if s >= P then s −= P.
  - op 2: s = a.
  - op 3: s = a−b; if negative then s += P.
- Stage 2 arithmetic:
  - op 0/2/3: r = s−c; if negative then r += P.
  - op 1: r = s.
  - The opcode travels with the data.
- Range check: lane error = (a >= P) || (b >= P and b is used by the op) || (c >= P and c is used by the op). It is computed in stage 1 and carried to out_err. Arithmetic still runs on the raw values; the result is defined only as the formula above and is not required to be in range.
- err_count increments by 1 on each output handshake where |out_err = 1, and saturates at 255.
- Simultaneous accept and consume with both stages full: the pipeline shifts, so nothing is lost or duplicated.
- Stall with out_ready = 0 and both stages full: in_ready = 0, and input data is ignored even while in_valid = 1.
- Reset mid-operation: all in-flight transactions are dropped and no out_valid appears after release until new input arrives.
- The unit adds no lane-to-lane interaction; each lane's result depends only on that lane's operands and the shared opcode.

Test Plan:
- Lane 0: a=5, b=7, c=20, op=0 → out_r lane0 = 3221225465 (P−8) two cycles later; out_err = 0.
- op=1, all lanes a = b = P−1 → every lane = 3221225471 (P−2). op=3, a=0, b=1, c=1 → P−2.
- out_ready held 0 while 3 back-to-back inputs are sent → in_ready drops after 2 accepted. Release out_ready → results emerge in order, 1 per cycle, with none lost.
- Lane 2 a = P, op=2, for 300 transactions → out_err = 4'b0100 on each; err_count saturates at 255; other lanes are correct.
- Assert reset with 2 transactions in flight → out_valid = 0 immediately, err_count = 0, and no stale output after release.
- Random sweep against a reference model: 10k transactions, all ops, legal operands, random out_ready → bit-exact, in order.
